// File: rtl/password_entry_shaper_pkg.sv
// Shared types and codes for the keypad entry front-end and the access-control FSM.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package password_entry_shaper_pkg;

  localparam int BCD_W = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COLLECT  = 2'd1,
    PRESENT  = 2'd2,
    COOLDOWN = 2'd3
  } state_t;

  // Request codes understood by the downstream access-control FSM.
  localparam logic [1:0] REQ_STALL  = 2'b11;
  localparam logic [1:0] REQ_CHANGE = 2'b01;
  localparam logic [1:0] REQ_ACCESS = 2'b00;

  function automatic logic is_bcd(input logic [BCD_W-1:0] d);
    return d <= 4'd9;
  endfunction

endpackage

// File: rtl/password_entry_shaper_if.sv
// Keypad-side inputs and FSM-side outputs of the entry shaper, bundled as one port.
// Latency: n/a (wiring only).
// Backpressure: none; data_load is a fire-and-forget strobe.
interface password_entry_shaper_if #(
  parameter int DIGITS = 4
);
  localparam int DW = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS + 1);

  logic [3:0]    key_digit;
  logic          key_press;
  logic          key_enter;
  logic          key_clear;
  logic [1:0]    request_sel;
  logic [DW-1:0] data_out;
  logic          data_load;
  logic [1:0]    request_out;
  logic [CW-1:0] digit_count;
  logic          entry_error;

  // Keypad / stimulus side.
  modport master (
    output key_digit, key_press, key_enter, key_clear, request_sel,
    input  data_out, data_load, request_out, digit_count, entry_error
  );

  // Entry shaper side.
  modport slave (
    input  key_digit, key_press, key_enter, key_clear, request_sel,
    output data_out, data_load, request_out, digit_count, entry_error
  );

endinterface

// File: rtl/password_entry_shaper_debouncer.sv
// Synchronises one raw button, filters bounce, and flags the clean rising edge.
// Latency: rise pulse appears 2 + DEBOUNCE_CYCLES cycles after a stable raw edge.
// Backpressure: none; the pulse is one cycle wide and is not held.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise
);
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  // Two-flop synchroniser for the asynchronous button.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Accept a new level only after DEBOUNCE_CYCLES equal differing samples; any agreeing sample restarts.
  always_ff @(posedge clk) begin
    if (rst) begin
      level <= 1'b0;
      cnt   <= '0;
      rise  <= 1'b0;
    end else begin
      rise <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync2;
        cnt   <= '0;
        rise  <= sync2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/password_entry_shaper.sv
// Debounces keypad buttons, assembles DIGITS BCD digits and hands the word to the access FSM.
// Latency: data_load follows the accepted enter event by 2 cycles (PRESENT, then the output register).
// Backpressure: none; after a load all buttons must be released before new entry starts.
module password_entry_shaper
  import password_entry_shaper_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int DIGITS          = 4,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  password_entry_shaper_if.slave  bus
);
  localparam int DW = BCD_W * DIGITS;
  localparam int CW = $clog2(DIGITS + 1);
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_FULL  = CW'(DIGITS);
  localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CYCLES - 1);

  state_t        state, state_nxt;
  logic [DW-1:0] shreg;
  logic [CW-1:0] count;
  logic [TW-1:0] timer;
  logic [DW-1:0] data_q;
  logic [1:0]    req_q;
  logic          load_q;
  logic          err_q;

  logic p_lvl, p_rise, e_lvl, e_rise, c_lvl, c_rise;
  logic clr_ev, ent_ev, dig_ev, any_ev, full;
  logic do_shift, do_clr, do_err, do_load;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_press (
    .clk(clk), .rst(rst), .raw(bus.key_press), .level(p_lvl), .rise(p_rise)
  );
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_enter (
    .clk(clk), .rst(rst), .raw(bus.key_enter), .level(e_lvl), .rise(e_rise)
  );
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
    .clk(clk), .rst(rst), .raw(bus.key_clear), .level(c_lvl), .rise(c_rise)
  );

  // Same-cycle events resolve clear > enter > digit; the losers are dropped.
  assign clr_ev = c_rise;
  assign ent_ev = e_rise & ~c_rise;
  assign dig_ev = p_rise & ~c_rise & ~e_rise;
  assign any_ev = p_rise | e_rise | c_rise;
  assign full   = (count == CNT_FULL);

  // Next-state and per-cycle actions; the first digit of an entry is captured on the IDLE->COLLECT event.
  always_comb begin
    state_nxt = state;
    do_shift  = 1'b0;
    do_clr    = 1'b0;
    do_err    = 1'b0;
    do_load   = 1'b0;
    case (state)
      IDLE: begin
        if (ent_ev) begin
          do_err = 1'b1;
        end else if (dig_ev) begin
          state_nxt = COLLECT;
          do_shift  = is_bcd(bus.key_digit);
        end
      end
      COLLECT: begin
        if (clr_ev) begin
          do_clr    = 1'b1;
          state_nxt = IDLE;
        end else if (ent_ev) begin
          if (full) state_nxt = PRESENT;
          else      do_err    = 1'b1;
        end else if (dig_ev) begin
          do_shift = is_bcd(bus.key_digit) && !full;
        end else if (timer == TIMER_MAX) begin
          do_clr    = 1'b1;
          state_nxt = IDLE;
        end
      end
      PRESENT: begin
        do_load   = 1'b1;
        do_clr    = 1'b1;
        state_nxt = COOLDOWN;
      end
      COOLDOWN: begin
        if (!(p_lvl || e_lvl || c_lvl)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Digit shift register and digit counter.
  always_ff @(posedge clk) begin
    if (rst || do_clr) begin
      shreg <= '0;
      count <= '0;
    end else if (do_shift) begin
      shreg <= {shreg[DW-BCD_W-1:0], bus.key_digit};
      count <= count + CW'(1);
    end
  end

  // Idle timer: runs only in COLLECT and restarts on any button event.
  always_ff @(posedge clk) begin
    if (rst || state != COLLECT || any_ev) timer <= '0;
    else                                   timer <= timer + TW'(1);
  end

  // Output registers: word and request captured together with the load strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      req_q  <= REQ_STALL;
      load_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      load_q <= do_load;
      err_q  <= do_err;
      if (do_load) begin
        data_q <= shreg;
        req_q  <= bus.request_sel;
      end
    end
  end

  assign bus.data_out    = data_q;
  assign bus.request_out = req_q;
  assign bus.data_load   = load_q;
  assign bus.entry_error = err_q;
  assign bus.digit_count = count;

endmodule

// File: tb/tb_password_entry_shaper.sv
// Randomised keypad stimulus against an action-level model of the entry rules.
// Latency: n/a.
// Backpressure: n/a.
module tb_password_entry_shaper;
  import password_entry_shaper_pkg::*;

  localparam int D  = 4;
  localparam int N  = 4;
  localparam int TO = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  password_entry_shaper_if #(.DIGITS(N)) bus ();

  password_entry_shaper #(
    .DEBOUNCE_CYCLES(D), .DIGITS(N), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Observed loads and errors, plus strobe-shape and output-stability checks.
  logic [15:0] got_word[$];
  logic [1:0]  got_req[$];
  int          err_seen = 0;
  logic        prev_load = 1'b0;
  logic        prev_err  = 1'b0;
  logic [15:0] last_out  = '0;

  always @(negedge clk) begin
    if (rst) begin
      prev_load = 1'b0;
      prev_err  = 1'b0;
      last_out  = '0;
    end else begin
      if (bus.data_load) begin
        chk("load_gap", prev_load, 0);
        got_word.push_back(bus.data_out);
        got_req.push_back(bus.request_out);
        last_out = bus.data_out;
      end else if (bus.data_out !== last_out) begin
        chk("out_stable", bus.data_out, last_out);
        last_out = bus.data_out;
      end
      if (bus.entry_error) begin
        chk("err_gap", prev_err, 0);
        err_seen++;
      end
      prev_load = bus.data_load;
      prev_err  = bus.entry_error;
    end
  end

  // Reference model: digits held as a list, word computed arithmetically.
  int          mq[$];
  bit          coll = 0;
  int          err_exp = 0;
  logic [15:0] exp_word[$];
  logic [1:0]  exp_req[$];

  function automatic logic [15:0] m_word();
    int w = 0;
    foreach (mq[i]) w = w * 16 + mq[i];
    return 16'(w);
  endfunction

  task automatic m_digit(input int d);
    coll = 1;
    if (d <= 9 && mq.size() < N) mq.push_back(d);
  endtask

  task automatic m_enter(input logic [1:0] req);
    if (coll && mq.size() == N) begin
      exp_word.push_back(m_word());
      exp_req.push_back(req);
      mq.delete();
      coll = 0;
    end else begin
      err_exp++;
    end
  endtask

  task automatic m_clear();
    mq.delete();
    coll = 0;
  endtask

  // Stimulus helpers.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_btn(input int which, input logic v);
    case (which)
      0:       bus.key_press = v;
      1:       bus.key_enter = v;
      default: bus.key_clear = v;
    endcase
  endtask

  task automatic press(input int which, input int hold, input int bnc);
    for (int i = 0; i < bnc; i++) begin set_btn(which, (i % 2) == 0); tick(); end
    set_btn(which, 1'b1);
    repeat (hold) tick();
    for (int i = 0; i < bnc; i++) begin set_btn(which, (i % 2) == 1); tick(); end
    set_btn(which, 1'b0);
    repeat (D + 8) tick();
  endtask

  task automatic act_digit(input int d);
    bus.key_digit = 4'(d);
    press(0, D + 4 + $urandom_range(0, 12), $urandom_range(0, 6));
    m_digit(d);
  endtask

  task automatic act_enter(input logic [1:0] req, input int hold);
    bus.request_sel = req;
    press(1, hold, $urandom_range(0, 6));
    m_enter(req);
  endtask

  task automatic act_clear();
    press(2, D + 4 + $urandom_range(0, 12), $urandom_range(0, 6));
    m_clear();
  endtask

  task automatic settle_check(input string tag);
    chk({tag, "_cnt"}, bus.digit_count, mq.size());
    chk({tag, "_nload"}, got_word.size(), exp_word.size());
    while (got_word.size() > 0 && exp_word.size() > 0) begin
      chk({tag, "_word"}, got_word.pop_front(), exp_word.pop_front());
      chk({tag, "_req"}, got_req.pop_front(), exp_req.pop_front());
    end
    got_word.delete(); got_req.delete(); exp_word.delete(); exp_req.delete();
    chk({tag, "_err"}, err_seen, err_exp);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, t0, r;
    bus.key_digit   = '0;
    bus.key_press   = 1'b0;
    bus.key_enter   = 1'b0;
    bus.key_clear   = 1'b0;
    bus.request_sel = REQ_STALL;

    // Reset state.
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_data", bus.data_out, 0);
    chk("rst_load", bus.data_load, 0);
    chk("rst_req", bus.request_out, 2'b11);
    chk("rst_cnt", bus.digit_count, 0);
    chk("rst_err", bus.entry_error, 0);
    rst = 1'b0;
    repeat (2) tick();

    // Clean 1,2,3,4 + enter with change request.
    for (int i = 1; i <= 4; i++) act_digit(i);
    act_enter(REQ_CHANGE, D + 6);
    settle_check("t1");
    chk("t1_out", bus.data_out, 16'h1234);
    chk("t1_reqout", bus.request_out, REQ_CHANGE);

    // Bouncy press: one digit, not before the filter latency after the last bounce.
    bus.key_digit = 4'd5;
    for (int i = 0; i < 10; i++) begin bus.key_press = (i % 2) == 0; tick(); end
    bus.key_press = 1'b1;
    t0  = cyc;
    lat = -1;
    for (int i = 0; i < 40 && lat < 0; i++) begin
      tick();
      if (bus.digit_count != 0) lat = cyc - t0;
    end
    chk("bounce_lat", (lat >= 2 + D), 1);
    repeat (10) tick();
    bus.key_press = 1'b0;
    repeat (D + 8) tick();
    m_digit(5);
    settle_check("t2");
    act_clear();
    settle_check("t2c");

    // Short entry rejected, then completed.
    act_digit(7); act_digit(8);
    act_enter(REQ_ACCESS, D + 6);
    settle_check("t3a");
    act_digit(9); act_digit(0);
    act_enter(REQ_ACCESS, D + 6);
    settle_check("t3b");
    chk("t3_out", bus.data_out, 16'h7890);

    // Fifth digit and non-BCD digits ignored.
    for (int i = 1; i <= 5; i++) act_digit(i);
    act_enter(REQ_STALL, D + 6);
    settle_check("t4a");
    chk("t4_out", bus.data_out, 16'h1234);
    act_digit(10); act_digit(1); act_digit(10); act_digit(2);
    settle_check("t4b");
    act_clear();

    // Clear and enter on the same cycle with 3 digits: clear wins.
    act_digit(3); act_digit(4); act_digit(5);
    bus.key_clear = 1'b1;
    bus.key_enter = 1'b1;
    repeat (D + 6) tick();
    bus.key_clear = 1'b0;
    bus.key_enter = 1'b0;
    repeat (D + 8) tick();
    m_clear();
    settle_check("t5a");

    // Enter held for 50 cycles gives a single load.
    for (int i = 0; i < 4; i++) act_digit(6 + i);
    act_enter(REQ_CHANGE, 50);
    settle_check("t5b");

    // Idle timeout discards a partial entry, not early.
    act_digit(2); act_digit(3);
    repeat (TO - 100) tick();
    chk("t6_pre_to", bus.digit_count, 2);
    repeat (120) tick();
    m_clear();
    settle_check("t6a");

    // Reset mid-entry, then a lone enter is rejected.
    act_digit(1); act_digit(2); act_digit(3);
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    m_clear();
    chk("t6_rst_cnt", bus.digit_count, 0);
    act_enter(REQ_ACCESS, D + 6);
    settle_check("t6b");

    // Two back-to-back words.
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < 4; i++) act_digit($urandom_range(0, 9));
      act_enter(2'(w), D + 4);
    end
    settle_check("t6c");

    // Randomised action sequence.
    for (int k = 0; k < 250; k++) begin
      r = $urandom_range(0, 99);
      if (r < 55) begin
        act_digit(($urandom_range(0, 4) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9));
      end else if (r < 80) begin
        act_enter(2'($urandom_range(0, 3)), D + 4 + $urandom_range(0, 30));
      end else if (r < 92) begin
        act_clear();
      end else if (r < 98) begin
        repeat ($urandom_range(0, 20)) tick();
      end else begin
        repeat (TO + 20) tick();
        m_clear();
      end
      settle_check("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
